// File: rtl/frame_streamer_if.sv
// dstream: valid/ready pixel stream between pipeline stages.
// The producer drives data/valid through modport out; the consumer drives ready.
interface dstream #(
  parameter int W = 30
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport out (output data, output valid, input ready);
  modport in  (input data, input valid, output ready);
endinterface

// File: rtl/frame_streamer.sv
// frame_streamer: reads one WIDTH x HEIGHT frame in raster order from a
// synchronous frame-buffer port and streams it on a dstream with sof/eol tags.
// A 2-entry output FIFO absorbs the one-cycle read latency under backpressure.
// Optional build macro FRAME_STREAMER_TEST_PATTERN_EN: rd_data is ignored,
// rd_en stays low, and 8 vertical colour bars are generated with the same timing.
module frame_streamer #(
  parameter int W      = 30,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  dstream.out           y,
  output logic          sof,
  output logic          eol
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int RW = $clog2(HEIGHT+1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH*HEIGHT-1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH-1);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          inflight;      // a read (or pattern word) lands in the FIFO this cycle
  logic          inflight_sof;
  logic          inflight_eol;
  logic [1:0]    occ;
  logic [W+1:0]  head;          // {sof, eol, data}
  logic [W+1:0]  tail;
  logic [W+1:0]  new_entry;
  logic [W-1:0]  push_data;
  logic [2:0]    credit;
  logic          pop;
  logic          issue;

  // Downstream sees only registered FIFO state; ready never reaches valid.
  assign y.valid = (occ != 2'd0);
  assign y.data  = head[W-1:0];
  assign sof     = head[W+1] & y.valid;
  assign eol     = head[W]   & y.valid;

  assign pop    = y.valid & y.ready;
  // Slots committed after this edge: stored + landing - leaving. Issue only if one is free.
  assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue  = (state == RUN) && (credit < 3'd2);

`ifdef FRAME_STREAMER_TEST_PATTERN_EN
  localparam logic [CW-1:0] LAST_BAR = CW'(WIDTH/8-1);

  logic [CW-1:0] bar_pos;
  logic [2:0]    bar_idx;
  logic [W-1:0]  pat_data;
  logic          unused_rd;

  function automatic logic [W-1:0] bar_colour(input logic [2:0] k);
    bar_colour = W'({(k[2] ? 10'h3FF : 10'h000),
                     (k[1] ? 10'h3FF : 10'h000),
                     (k[0] ? 10'h3FF : 10'h000)});
  endfunction

  assign rd_en     = 1'b0;
  assign push_data = pat_data;
  assign unused_rd = ^rd_data;

  // Bar counters track col; the pattern word is produced one cycle after issue like a read.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bar_pos  <= {CW{1'b0}};
      bar_idx  <= 3'd0;
      pat_data <= {W{1'b0}};
    end else if (issue) begin
      pat_data <= bar_colour(bar_idx);
      if (col == LAST_COL) begin
        bar_pos <= {CW{1'b0}};
        bar_idx <= 3'd0;
      end else if (bar_pos == LAST_BAR) begin
        bar_pos <= {CW{1'b0}};
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + COL_ONE;
      end
    end
  end
`else
  assign rd_en     = issue;
  assign push_data = rd_data;
`endif

  assign new_entry = {inflight_sof, inflight_eol, push_data};

  // Frame control: state, raster counters, read address and in-flight tag stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      rd_addr      <= {AW{1'b0}};
      col          <= {CW{1'b0}};
      row          <= {RW{1'b0}};
      inflight     <= 1'b0;
      inflight_sof <= 1'b0;
      inflight_eol <= 1'b0;
    end else begin
      inflight   <= issue;
      frame_done <= 1'b0;
      if (issue) begin
        inflight_sof <= (col == {CW{1'b0}}) && (row == {RW{1'b0}});
        inflight_eol <= (col == LAST_COL);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            if (rd_addr == LAST_ADDR) begin
              state   <= DRAIN;
              rd_addr <= {AW{1'b0}};
              col     <= {CW{1'b0}};
              row     <= {RW{1'b0}};
            end else begin
              rd_addr <= rd_addr + ADDR_ONE;
              if (col == LAST_COL) begin
                col <= {CW{1'b0}};
                row <= row + ROW_ONE;
              end else begin
                col <= col + COL_ONE;
              end
            end
          end
        end
        DRAIN: begin
          if (!inflight && (occ == 2'd1) && pop) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Two-entry output FIFO with the head register driving the stream.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      occ  <= 2'd0;
      head <= {(W+2){1'b0}};
      tail <= {(W+2){1'b0}};
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head <= new_entry;
          end else begin
            tail <= new_entry;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= new_entry;
          end else begin
            head <= tail;
            tail <= new_entry;
          end
        end
        default: begin
          occ <= occ;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer on a reduced 64x8 frame.
module tb_frame_streamer;
  localparam int W      = 30;
  localparam int WIDTH  = 64;
  localparam int HEIGHT = 8;
  localparam int N      = WIDTH*HEIGHT;
  localparam int AW     = $clog2(N);

  typedef struct packed {
    logic         sof;
    logic         eol;
    logic [W-1:0] data;
  } pix_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          sof;
  logic          eol;

  dstream #(.W(W)) y_if ();

  frame_streamer #(.W(W), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .y          (y_if),
    .sof        (sof),
    .eol        (eol)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [N];
  pix_t exp_q [$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   pix_idx = 0;
  int   done_count = 0;
  int   done_base = 0;
  int   done_cyc = -1;
  int   first_valid_cyc = -1;
  int   rd_en_seen = 0;
  int   start_cyc = 0;
  bit   rand_ready = 1'b0;
  bit   hold_pending = 1'b0;
  pix_t held;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous frame buffer: data one cycle after rd_en, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : W'($urandom);

  // Downstream ready: all-ones or a random 50% pattern.
  initial begin
    y_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      y_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [W-1:0] model_data(input int i);
`ifdef FRAME_STREAMER_TEST_PATTERN_EN
    int k;
    k = (i % WIDTH) / (WIDTH/8);
    model_data = {(((k & 4) != 0) ? 10'h3FF : 10'h000),
                  (((k & 2) != 0) ? 10'h3FF : 10'h000),
                  (((k & 1) != 0) ? 10'h3FF : 10'h000)};
`else
    model_data = mem[i];
`endif
  endfunction

  task automatic push_frame();
    pix_t p;
    for (int i = 0; i < N; i++) begin
      p.sof  = (i == 0);
      p.eol  = ((i % WIDTH) == WIDTH-1);
      p.data = model_data(i);
      exp_q.push_back(p);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold stability.
  always @(negedge clk) begin
    pix_t got;
    pix_t e;
    if (resetn === 1'b1) begin
      got = {sof, eol, y_if.data};
      if (hold_pending) begin
        vectors++;
        if (!(y_if.valid === 1'b1 && got === held)) begin
          miscompares++;
          $display("FAIL hold_stable: got valid=%0b %h, required valid=1 %h", y_if.valid, got, held);
        end
      end
      hold_pending = (y_if.valid === 1'b1) && (y_if.ready === 1'b0);
      held = got;
      if (y_if.valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (y_if.valid === 1'b1 && y_if.ready === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_pixel: got %h, required no pixel", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL pixel[%0d]: got sof=%0b eol=%0b data=%h, required sof=%0b eol=%0b data=%h",
                     pix_idx, got.sof, got.eol, got.data, e.sof, e.eol, e.data);
          end
        end
        pix_idx++;
      end
      if (frame_done === 1'b1) begin
        done_count++;
        done_cyc = cyc;
      end
      if (rd_en === 1'b1) rd_en_seen++;
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic begin_frame();
    pix_idx = 0;
    first_valid_cyc = -1;
    done_cyc = -1;
    rd_en_seen = 0;
    done_base = done_count;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_count == done_base && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (done_count == done_base) begin
      miscompares++;
      $display("FAIL %s_done: got no frame_done in %0d cycles, required one", name, budget);
    end
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_pixel_count"}, 64'(pix_idx), 64'(N));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    resetn = 1'b0;
    start  = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = W'($urandom);
    repeat (3) step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_rd_en", 64'(rd_en), 64'd0);
    check("reset_rd_addr", 64'(rd_addr), 64'd0);
    check("reset_valid", 64'(y_if.valid), 64'd0);
    check("reset_sof_eol", 64'({sof, eol}), 64'd0);
    resetn = 1'b1;
    repeat (2) step();

    // Frame A: full throughput, exact latency, start ignored in RUN and DONE.
    push_frame();
    begin_frame();
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    for (int k = 1; k < N+3; k++) begin
      start = (k == 50);
      step();
    end
    start = 1'b0;
    check("done_pulse", 64'(frame_done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("first_valid_cycle", 64'(first_valid_cyc - start_cyc), 64'd3);
    check("done_cycle", 64'(done_cyc - start_cyc), 64'(N+3));
    check("frame_a_pixels", 64'(pix_idx), 64'(N));
    check("frame_a_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef FRAME_STREAMER_TEST_PATTERN_EN
    check("frame_a_reads", 64'(rd_en_seen), 64'd0);
`else
    check("frame_a_reads", 64'(rd_en_seen), 64'(N));
`endif
    repeat (20) step();
    check("one_frame_only", 64'(done_count - done_base), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(y_if.valid), 64'd0);

    // Frame B: random backpressure.
    rand_ready = 1'b1;
    push_frame();
    begin_frame();
    pulse_start();
    wait_done("frame_b", 8*N);
    repeat (5) step();

    // Frame C: reset around pixel 100 aborts without frame_done.
    push_frame();
    begin_frame();
    pulse_start();
    n = 0;
    while (pix_idx < 100 && n < 8*N) begin
      step();
      n++;
    end
    check("reached_pixel_100", 64'(pix_idx >= 100), 64'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("abort_valid", 64'(y_if.valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_frame_done", 64'(frame_done), 64'd0);
    exp_q.delete();
    repeat (10) step();
    check("abort_no_done", 64'(done_count - done_base), 64'd0);
    check("abort_idle_valid", 64'(y_if.valid), 64'd0);

    // Frame D: restart after abort begins at address 0 with sof.
    push_frame();
    begin_frame();
    pulse_start();
`ifndef FRAME_STREAMER_TEST_PATTERN_EN
    check("restart_addr", 64'(rd_addr), 64'd0);
`endif
    wait_done("frame_d", 8*N);
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
